// File: rtl/burst_arb_pkg.sv
// Shared types and sizing for the two-requester burst arbiter in front of the
// burst-transaction datapath.
package burst_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int LEN_WIDTH = 4;
    localparam int RD_LAT    = 2;

    // Widths of the address generator / SRAM datapath this block drives
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;
    localparam int STRIDE_LEN = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BURST,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRIDE_LEN-1:0] stride;
        logic [LEN_WIDTH-1:0]  len;
    } burst_desc_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; the pointer names the requester that
// wins the next tie and flips to the loser after every grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       any_req,
    output logic       winner
);

    logic rr_ptr_reg;

    always_comb begin
        any_req = |req;
        winner  = 1'b0;
        if (req[0] && req[1]) begin
            winner = rr_ptr_reg;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (advance) begin
            rr_ptr_reg <= ~winner;
        end
    end

endmodule

// File: rtl/burst_sram_arbiter.sv
// Round-robin burst sequencer: latches one descriptor per grant and drives the
// address generator / SRAM control, returning write acks and tagged read data.
module burst_sram_arbiter
    import burst_arb_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   req_wr,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][STRIDE_LEN-1:0]   req_stride,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   wr_ack,
    output logic                                 rd_valid,
    output logic                                 rd_id,
    output logic [DATA_WIDTH-1:0]                rd_out,
    output logic [NUM_REQ-1:0]                   done,
    output logic                                 busy,
    output logic [ADDR_WIDTH-1:0]                addr_top,
    output logic [STRIDE_LEN-1:0]                stride,
    output logic                                 burst_en,
    output logic                                 wren,
    output logic                                 rden,
    output logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH-1:0]                rd_data
);

    state_t                state_reg, state_next;
    burst_desc_t           desc_reg, desc_next;
    logic                  owner_reg, owner_next;
    logic [LEN_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [RD_LAT-1:0]     rden_sr_reg, rden_sr_next;

    logic any_req;
    logic winner;
    logic grant;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (grant),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            desc_reg    <= '0;
            owner_reg   <= 1'b0;
            cnt_reg     <= '0;
            rden_sr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            desc_reg    <= desc_next;
            owner_reg   <= owner_next;
            cnt_reg     <= cnt_next;
            rden_sr_reg <= rden_sr_next;
        end
    end

    // cnt_reg counts beats in BURST and is reused as the drain timer in DRAIN
    always_comb begin
        state_next = state_reg;
        desc_next  = desc_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        grant      = 1'b0;
        burst_en   = 1'b0;
        wren       = 1'b0;
        rden       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by rst so no grant leaks out while reset is held
                if (any_req && !rst) begin
                    grant            = 1'b1;
                    owner_next       = winner;
                    desc_next.wr     = req_wr[winner];
                    desc_next.addr   = req_addr[winner];
                    desc_next.stride = req_stride[winner];
                    desc_next.len    = req_len[winner];
                    cnt_next         = '0;
                    state_next       = (req_len[winner] == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_next = BURST;
            end
            BURST: begin
                burst_en = 1'b1;
                wren     = desc_reg.wr;
                rden     = !desc_reg.wr;
                if (cnt_reg == desc_reg.len - 1'b1) begin
                    cnt_next   = '0;
                    state_next = desc_reg.wr ? DONE : DRAIN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_reg == LEN_WIDTH'(RD_LAT - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read-valid pipeline mirrors the datapath's address register + SRAM read
    assign rden_sr_next[0] = rden;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
        assign rden_sr_next[gi] = rden_sr_reg[gi-1];
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_out
        assign gnt[gi]    = grant && (winner == 1'(gi));
        assign wr_ack[gi] = wren && (owner_reg == 1'(gi));
        assign done[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
    end

    assign rd_valid = rden_sr_reg[RD_LAT-1];
    assign rd_id    = rd_valid && owner_reg;
    assign rd_out   = rd_valid ? rd_data : '0;
    assign busy     = (state_reg != IDLE);
    assign addr_top = desc_reg.addr;
    assign stride   = desc_reg.stride;
    assign wr_data  = wren ? req_wdata[owner_reg] : '0;

endmodule

// File: tb/tb_burst_sram_arbiter.sv
// Directed bench for burst_sram_arbiter with a small address-generator/SRAM
// model standing in for the datapath.
module tb_burst_sram_arbiter;
    import burst_arb_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst = 1'b1;
    logic [NUM_REQ-1:0]                 req = '0;
    logic [NUM_REQ-1:0]                 req_wr = '0;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ-1:0][STRIDE_LEN-1:0] req_stride = '0;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len = '0;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]                 gnt, wr_ack, done;
    logic                               rd_valid, rd_id, busy;
    logic [DATA_WIDTH-1:0]              rd_out, wr_data, rd_data;
    logic [ADDR_WIDTH-1:0]              addr_top;
    logic [STRIDE_LEN-1:0]              stride;
    logic                               burst_en, wren, rden;

    burst_sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .wr_ack     (wr_ack),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_out     (rd_out),
        .done       (done),
        .busy       (busy),
        .addr_top   (addr_top),
        .stride     (stride),
        .burst_en   (burst_en),
        .wren       (wren),
        .rden       (rden),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Datapath model: generator loads when burst_en=0, steps by stride otherwise;
    // SRAM uses the registered address, read data appears two cycles after rden.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mem [256];
    logic [DATA_WIDTH-1:0] stage1 = '0;
    initial rd_data = '0;

    always @(posedge clk) begin
        addr_q <= burst_en ? addr_q + stride : addr_top;
        if (wren) mem[addr_q] <= wr_data;
        stage1  <= mem[addr_q];
        rd_data <= stage1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    logic [DATA_WIDTH-1:0] wd [2][8];
    int gnt_n [2];
    int ack_n [2];
    int done_n [2];
    int first_gnt, first_ack, last_ack, done_cyc, first_rden;
    int rv_n, rv_first, rv_last, bad_rvid, overlap, en_seen, wd_bad;
    int exp_id;
    int gnt_order [$];
    logic [DATA_WIDTH-1:0] rv_q [$];

    // Steps cycle by cycle from the current negedge, acting as both requesters
    task automatic run(input int n_cyc, input bit drop_on_done, input bit stop_on_done);
        for (int i = 0; i < 2; i++) begin
            gnt_n[i] = 0; ack_n[i] = 0; done_n[i] = 0;
        end
        first_gnt = -1; first_ack = -1; last_ack = -1; done_cyc = -1; first_rden = -1;
        rv_n = 0; rv_first = -1; rv_last = -1; bad_rvid = 0; overlap = 0; en_seen = 0; wd_bad = 0;
        gnt_order.delete();
        rv_q.delete();
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            if (cyc > 0) @(negedge clk);
            req_wdata[0] = wd[0][ack_n[0] % 8];
            req_wdata[1] = wd[1][ack_n[1] % 8];
            #1;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    gnt_n[i]++;
                    gnt_order.push_back(i);
                    if (first_gnt < 0) first_gnt = cyc;
                end
                if (wr_ack[i]) begin
                    if (wr_data !== wd[i][ack_n[i] % 8]) wd_bad++;
                    ack_n[i]++;
                    if (first_ack < 0) first_ack = cyc;
                    last_ack = cyc;
                end
            end
            if (rden && first_rden < 0) first_rden = cyc;
            if (rd_valid) begin
                rv_n++;
                rv_q.push_back(rd_out);
                if (rd_id !== 1'(exp_id)) bad_rvid++;
                if (rv_first < 0) rv_first = cyc;
                rv_last = cyc;
            end
            if (wren && rden) overlap++;
            if (burst_en || wren || rden) en_seen++;
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    done_n[i]++;
                    done_cyc = cyc;
                    if (drop_on_done) req[i] = 1'b0;
                end
            end
            if (stop_on_done && done != '0) break;
        end
    endtask

    initial begin
        int quiet_bad;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++)
                wd[i][k] = 16'hA000 + DATA_WIDTH'(i * 16'h1000) + DATA_WIDTH'(k);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {burst_en, wren, rden}, 0);
        chk("rst_addr_top", addr_top, 0);
        chk("rst_stride", stride, 0);
        chk("rst_outs", {wr_ack, done, rd_valid, wr_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Req0 write 0x10 stride 2 len 4
        @(negedge clk);
        req[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 8'h10; req_stride[0] = 8'd2; req_len[0] = 4'd4;
        run(30, 1, 1);
        chk("w_gnt_count", gnt_n[0], 1);
        chk("w_ack_count", ack_n[0], 4);
        chk("w_first_ack", first_ack, 2);
        chk("w_done_cyc", done_cyc, 6);
        chk("w_done_after_last", done_cyc - last_ack, 1);
        chk("w_wdata", wd_bad, 0);
        chk("w_mem10", mem[8'h10], 16'hA000);
        chk("w_mem12", mem[8'h12], 16'hA001);
        chk("w_mem14", mem[8'h14], 16'hA002);
        chk("w_mem16", mem[8'h16], 16'hA003);

        // Req1 read back the same four locations
        @(negedge clk);
        exp_id = 1;
        req[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 8'h10; req_stride[1] = 8'd2; req_len[1] = 4'd4;
        run(30, 1, 1);
        chk("r_gnt1", gnt_n[1], 1);
        chk("r_rv_count", rv_n, 4);
        chk("r_rv_id", bad_rvid, 0);
        chk("r_first_rden", first_rden, 2);
        chk("r_lat", rv_first - first_rden, RD_LAT);
        chk("r_done_cyc", done_cyc, 8);
        chk("r_done_after_rv", done_cyc - rv_last, 1);
        chk("r_overlap", overlap, 0);
        if (rv_q.size() == 4) begin
            chk("r_data0", rv_q[0], 16'hA000);
            chk("r_data1", rv_q[1], 16'hA001);
            chk("r_data2", rv_q[2], 16'hA002);
            chk("r_data3", rv_q[3], 16'hA003);
        end

        // Both requesting from reset, len 2 each, held across three bursts
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        req_wr = 2'b11; req_addr[0] = 8'h80; req_addr[1] = 8'h90;
        req_stride[0] = 8'd1; req_stride[1] = 8'd1; req_len[0] = 4'd2; req_len[1] = 4'd2;
        req = 2'b11;
        run(11, 0, 0);
        chk("rr_count", gnt_order.size(), 3);
        if (gnt_order.size() == 3) begin
            chk("rr_order0", gnt_order[0], 0);
            chk("rr_order1", gnt_order[1], 1);
            chk("rr_order2", gnt_order[2], 0);
        end
        @(negedge clk);
        req = 2'b00;
        run(20, 1, 1);
        chk("drop_ignored_done", done_n[0], 1);

        // Zero-length burst
        @(negedge clk);
        req[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 8'h40; req_stride[0] = 8'd1; req_len[0] = 4'd0;
        run(10, 1, 1);
        chk("z_gnt_cyc", first_gnt, 0);
        chk("z_done_cyc", done_cyc, 1);
        chk("z_done", done_n[0], 1);
        chk("z_no_ctl", en_seen, 0);

        // Address wrap: 0xFE + 4 -> 0x02 -> 0x06
        @(negedge clk);
        req[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 8'hFE; req_stride[0] = 8'd4; req_len[0] = 4'd3;
        run(20, 1, 1);
        chk("wrap_acks", ack_n[0], 3);
        chk("wrap_memFE", mem[8'hFE], 16'hA000);
        chk("wrap_mem02", mem[8'h02], 16'hA001);
        chk("wrap_mem06", mem[8'h06], 16'hA002);

        // Reset during beat 2 of a len-8 read
        @(negedge clk);
        req[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 8'h10; req_stride[1] = 8'd1; req_len[1] = 4'd8;
        #1;
        chk("ab_gnt", gnt, 2'b10);
        repeat (3) @(negedge clk);
        #1;
        chk("ab_beat2_rden", rden, 1);
        chk("ab_beat2_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("ab_ctl_zero", {burst_en, wren, rden, busy}, 0);
        chk("ab_addr_zero", {addr_top, stride}, 0);
        chk("ab_outs_zero", {gnt, wr_ack, done, rd_valid, rd_id, rd_out, wr_data}, 0);
        quiet_bad = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done != '0 || gnt != '0 || rd_valid) quiet_bad++;
        end
        chk("ab_quiet", quiet_bad, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ab_regrant1", gnt, 2'b10);
        run(40, 1, 1);
        chk("ab_rerun_rv", rv_n, 8);
        chk("ab_rerun_done", done_n[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
